// File: rtl/keypad_decoder.sv
// keypad_decoder: receive side of a 4x4 matrix keypad.
// The external column scanner drives one-hot column strobes and a sample
// pulse per column. This block samples the synchronized rows, assembles
// one result per full scan (NONE / SINGLE(code) / MULTI), debounces the
// scan results and emits accepted key events.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   row        raw row lines, active-high, asynchronous to clk
//   column     one-hot column currently driven (bit i = column i)
//   sample_en  one-cycle pulse: column is stable, rows may be sampled
//   key_code   last accepted key, row_idx*4 + col_idx
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high from acceptance until debounced release
//   multi_key  last completed scan saw more than one pressed key
//   scan_err   one-cycle pulse after a sample_en with a non-one-hot column
//   dbg_state  debounce FSM state (0 IDLE, 1 DEBOUNCE, 2 PRESSED, 3 RELEASE)
//
// Handshake: sample_en is a single-cycle strobe with no back-pressure; a
// scan is the samples from column 0001 through column 1000, and its result
// is handed to the debounce FSM as a one-cycle internal pulse (res_valid)
// that the FSM always consumes on the following cycle.
module keypad_decoder #(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CNT_W          = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] column,
  input  logic       sample_en,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key,
  output logic       scan_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

  localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_SCANS);

  // Index of the set bit in a one-hot nibble.
  function automatic logic [1:0] idx4(input logic [3:0] v);
    case (v)
      4'b0010: idx4 = 2'd1;
      4'b0100: idx4 = 2'd2;
      4'b1000: idx4 = 2'd3;
      default: idx4 = 2'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------- sync
  logic [3:0] row_m, row_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m <= 4'b0;
      row_s <= 4'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // -------------------------------------------------------- scan assembly
  logic       armed;      // a scan has started with column 0001
  logic       acc_hit, acc_multi;
  logic [3:0] acc_code;
  logic       res_valid;
  res_t       res_kind;
  logic [3:0] res_code;

  logic       col_ok, col_first, col_last;
  logic       b_hit, b_multi;
  logic [3:0] b_code;
  logic       f_hit, f_multi;
  logic [3:0] f_code;

  // Fold the current sample into the accumulator. Column 0001 folds into
  // a cleared accumulator so a new scan never inherits stale hits.
  always_comb begin
    col_ok    = $onehot(column);
    col_first = (column == 4'b0001);
    col_last  = (column == 4'b1000);
    b_hit     = col_first ? 1'b0 : acc_hit;
    b_multi   = col_first ? 1'b0 : acc_multi;
    b_code    = col_first ? 4'b0 : acc_code;
    f_hit     = b_hit;
    f_multi   = b_multi;
    f_code    = b_code;
    if (row_s != 4'b0) begin
      if (!$onehot(row_s) || b_hit) begin
        f_multi = 1'b1;
      end else begin
        f_hit  = 1'b1;
        f_code = {idx4(row_s), idx4(column)};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'b0;
      res_valid <= 1'b0;
      res_kind  <= RES_NONE;
      res_code  <= 4'b0;
      multi_key <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      scan_err  <= 1'b0;
      if (sample_en) begin
        if (!col_ok) begin
          // Bad strobe: drop the partial scan and wait for a fresh 0001.
          armed     <= 1'b0;
          acc_hit   <= 1'b0;
          acc_multi <= 1'b0;
          acc_code  <= 4'b0;
          scan_err  <= 1'b1;
        end else if (col_first || armed) begin
          if (col_last) begin
            res_valid <= 1'b1;
            res_kind  <= f_multi ? RES_MULTI : (f_hit ? RES_SINGLE : RES_NONE);
            res_code  <= f_code;
            multi_key <= f_multi;
            armed     <= 1'b0;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'b0;
          end else begin
            armed     <= 1'b1;
            acc_hit   <= f_hit;
            acc_multi <= f_multi;
            acc_code  <= f_code;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- debounce FSM
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n, code_n;
  logic             held_n, valid_n;
  logic             res_single, res_none;

  assign dbg_state = state;

  always_comb begin
    res_single = res_valid && (res_kind == RES_SINGLE);
    res_none   = res_valid && (res_kind == RES_NONE);
    cnt_inc    = (cnt >= DB) ? DB : cnt + CNT_W'(1);  // saturating
    state_n    = state;
    cnt_n      = cnt;
    cand_n     = cand;
    code_n     = key_code;
    held_n     = key_held;
    valid_n    = 1'b0;
    case (state)
      IDLE: begin
        if (res_single) begin
          if (DEBOUNCE_SCANS == 1) begin
            state_n = PRESSED;
            cnt_n   = '0;
            code_n  = res_code;
            valid_n = 1'b1;
            held_n  = 1'b1;
          end else begin
            state_n = DEBOUNCE;
            cnt_n   = CNT_W'(1);
            cand_n  = res_code;
          end
        end
      end
      DEBOUNCE: begin
        if (res_single && (res_code == cand)) begin
          cnt_n = cnt_inc;
          if (cnt_inc == DB) begin
            state_n = PRESSED;
            cnt_n   = '0;
            code_n  = cand;
            valid_n = 1'b1;
            held_n  = 1'b1;
          end
        end else if (res_single) begin
          cnt_n  = CNT_W'(1);
          cand_n = res_code;
        end else if (res_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      PRESSED: begin
        // Any non-empty scan keeps the key held; only an empty scan starts
        // the release count.
        if (res_none) begin
          if (DEBOUNCE_SCANS == 1) begin
            state_n = IDLE;
            cnt_n   = '0;
            held_n  = 1'b0;
          end else begin
            state_n = RELEASE;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      RELEASE: begin
        if (res_none) begin
          cnt_n = cnt_inc;
          if (cnt_inc == DB) begin
            state_n = IDLE;
            cnt_n   = '0;
            held_n  = 1'b0;
          end
        end else if (res_valid) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'b0;
      key_code  <= 4'b0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_held  <= held_n;
      key_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] column;
  logic       sample_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;
  logic       scan_err;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;           // key_valid pulses seen
  logic [3:0] vcode = 4'h0;  // key_code at the last pulse
  int base;

  localparam logic [1:0] S_IDLE = 2'd0, S_DEB = 2'd1, S_PRESSED = 2'd2;

  keypad_decoder #(.DEBOUNCE_SCANS(3), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .row(row), .column(column),
    .sample_en(sample_en), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .multi_key(multi_key), .scan_err(scan_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid) begin
      vcnt  <= vcnt + 1;
      vcode <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Rows settle for two cycles before the strobe so they clear the synchronizer.
  task automatic sample(input logic [3:0] col, input logic [3:0] r);
    @(negedge clk);
    row = r;
    idle(2);
    column    = col;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    column    = 4'b0;
  endtask

  function automatic logic [15:0] km(input int k);
    logic [15:0] one;
    one = 16'h1;
    return one << k;
  endfunction

  // m bit (r*4+c) set = key at row r, column c pressed.
  task automatic scan(input logic [15:0] m);
    for (int c = 0; c < 4; c++) begin
      logic [3:0] col;
      col = 4'(1 << c);
      sample(col, {m[12+c], m[8+c], m[4+c], m[c]});
    end
  endtask

  task automatic scans(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      scan(m);
      idle(3);
    end
  endtask

  initial begin
    reset = 1'b1; row = 4'b0; column = 4'b0; sample_en = 1'b0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_code",  key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held",  key_held, 0);
    check("rst_multi", multi_key, 0);
    check("rst_err",   scan_err, 0);
    check("rst_state", dbg_state, S_IDLE);

    // Reset mid-debounce, then a clean press of key 6.
    scans(km(6), 2);
    check("deb_state", dbg_state, S_DEB);
    do_reset();
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_held",  key_held, 0);
    check("mid_rst_code",  key_code, 0);
    base = vcnt;
    scans(km(6), 1);
    check("k6_no_early", vcnt - base, 0);
    scans(km(6), 2);
    check("k6_valid_cnt", vcnt - base, 1);
    check("k6_vcode",     vcode, 6);
    check("k6_code",      key_code, 6);
    check("k6_held",      key_held, 1);
    scans(16'h0, 3);
    check("k6_released", key_held, 0);

    // Key 12 press and release with release timing.
    base = vcnt;
    scans(km(12), 3);
    check("k12_valid_cnt", vcnt - base, 1);
    check("k12_code", key_code, 12);
    scans(16'h0, 2);
    check("k12_held_2empty", key_held, 1);
    scan(16'h0);
    check("k12_held_at_sample", key_held, 1);
    @(negedge clk);
    check("k12_held_fall", key_held, 0);
    check("k12_code_kept", key_code, 12);
    idle(3);

    // Bounce: 5, none, 5, 5 -> nothing; one more 5 -> accept.
    base = vcnt;
    scans(km(5), 1);
    scans(16'h0, 1);
    scans(km(5), 2);
    check("bounce_none", vcnt - base, 0);
    scans(km(5), 1);
    check("bounce_valid", vcnt - base, 1);
    check("bounce_code", key_code, 5);
    scans(16'h0, 3);

    // Two keys in one scan -> multi, no key; then key 1 alone.
    base = vcnt;
    scans(km(1) | km(11), 1);
    check("multi_set", multi_key, 1);
    scans(km(1) | km(11), 2);
    check("multi_no_valid", vcnt - base, 0);
    check("multi_state", dbg_state, S_IDLE);
    scans(km(1), 1);
    check("multi_clear", multi_key, 0);
    scans(km(1), 2);
    check("k1_valid", vcnt - base, 1);
    check("k1_code", key_code, 1);
    scans(16'h0, 3);

    // Illegal column mid-scan: error pulse, scan dropped, count kept.
    base = vcnt;
    scans(km(2), 2);
    sample(4'b0001, 4'b0000);
    sample(4'b0010, 4'b0000);
    check("err_before", scan_err, 0);
    sample(4'b0110, 4'b0000);
    check("err_pulse", scan_err, 1);
    @(negedge clk);
    check("err_one_cycle", scan_err, 0);
    sample(4'b0100, 4'b0001);
    sample(4'b1000, 4'b0000);
    idle(3);
    check("err_state_kept", dbg_state, S_DEB);
    check("err_no_valid", vcnt - base, 0);
    scans(km(2), 1);
    check("err_then_valid", vcnt - base, 1);
    check("err_then_code", key_code, 2);
    scans(16'h0, 3);

    // Held key 9 slides to key 10 without an empty scan.
    base = vcnt;
    scans(km(9), 3);
    check("k9_valid", vcnt - base, 1);
    check("k9_code", key_code, 9);
    scans(km(10), 3);
    check("k10_no_valid", vcnt - base, 1);
    check("k10_code_kept", key_code, 9);
    check("k10_held", key_held, 1);
    check("k10_state", dbg_state, S_PRESSED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
